dbg_chain_arbiter: RTL and testbench

- Shares the single serial debug link from the TAP (dbg_sel/dbg_tdi/dbg_tdo plus the tap_* state strobes) between NTARGETS debug targets, e.g. CPU debug unit, bus master, trace.
- Every DR scan starts with a header. The header either selects a new target or routes the remaining bits to the currently selected target.
- Runs entirely in the tap_tck domain, between the TAP controller and the per-target debug units.

---
 rtl/dbg_chain_arbiter_pkg.sv | 24 ++
 rtl/dbg_chain_arbiter_if.sv | 44 ++++
 rtl/dbg_chain_arbiter.sv | 153 +++++++++++++++
 tb/tb_dbg_chain_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_chain_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_arb_pkg : shared types and constants for dbg_chain_arbiter        |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package dbg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_FLAG = 3'd1,
        HDR_SEL  = 3'd2,
        ROUTE    = 3'd3,
        DISCARD  = 3'd4
    } arb_state_e;

    localparam logic HDR_SELECT = 1'b1;
    localparam logic HDR_ROUTE  = 1'b0;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_chain_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_chain_arbiter_if : TAP-side strobes and per-target serial links   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
interface dbg_chain_arbiter_if #(
    parameter int NTARGETS = 3
);
    import dbg_arb_pkg::*;

    localparam int SEL_W = sel_width(NTARGETS);

    logic                tap_TestLogicReset;
    logic                tap_CaptureDR;
    logic                tap_ShiftDR;
    logic                tap_PauseDR;
    logic                tap_UpdateDR;
    logic                dbg_sel;
    logic                dbg_tdi;
    logic                dbg_tdo;
    logic                tgt_tdi;
    logic [NTARGETS-1:0] tgt_tdo;
    logic [NTARGETS-1:0] tgt_capture;
    logic [NTARGETS-1:0] tgt_shift;
    logic [NTARGETS-1:0] tgt_update;
    logic [SEL_W-1:0]    cur_sel;
    logic                sel_err;

    modport master (
        output tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR,
               tap_UpdateDR, dbg_sel, dbg_tdi, tgt_tdo,
        input  dbg_tdo, tgt_tdi, tgt_capture, tgt_shift, tgt_update,
               cur_sel, sel_err
    );

    modport slave (
        input  tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_PauseDR,
               tap_UpdateDR, dbg_sel, dbg_tdi, tgt_tdo,
        output dbg_tdo, tgt_tdi, tgt_capture, tgt_shift, tgt_update,
               cur_sel, sel_err
    );

endinterface
`default_nettype wire

// File: rtl/dbg_chain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_chain_arbiter : header-driven sharing of one TAP DR chain         |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module dbg_chain_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int NTARGETS = 3
) (
    input  wire                 tap_tck,
    input  wire                 jtag_trstn,
    dbg_chain_arbiter_if.slave  bus
);

    localparam int SEL_W   = sel_width(NTARGETS);
    localparam int c_cnt_w = sel_width(SEL_W + 1);
    localparam logic [SEL_W:0] c_ntargets = (SEL_W + 1)'(NTARGETS);

    arb_state_e         r_state,      w_state_nxt;
    logic [SEL_W-1:0]   r_cur_sel,    w_cur_sel_nxt;
    logic               r_sel_err,    w_sel_err_nxt;
    logic [SEL_W:0]     r_status_sr,  w_status_sr_nxt;
    logic [SEL_W-1:0]   r_new_sel,    w_new_sel_nxt;
    logic [c_cnt_w-1:0] r_bit_cnt,    w_bit_cnt_nxt;
    logic               r_cap,        w_cap_nxt;

    logic [SEL_W:0]      w_status_shift;
    logic                w_route;
    logic [NTARGETS-1:0] w_capture;
    logic [NTARGETS-1:0] w_shift;
    logic [NTARGETS-1:0] w_update;

    assign w_status_shift = {1'b0, r_status_sr[SEL_W:1]};
    assign w_route        = (r_state == ROUTE);

    always_ff @(posedge tap_tck) begin
        if (!jtag_trstn) begin
            r_state     <= IDLE;
            r_cur_sel   <= '0;
            r_sel_err   <= 1'b0;
            r_status_sr <= '0;
            r_new_sel   <= '0;
            r_bit_cnt   <= '0;
            r_cap       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_sel   <= w_cur_sel_nxt;
            r_sel_err   <= w_sel_err_nxt;
            r_status_sr <= w_status_sr_nxt;
            r_new_sel   <= w_new_sel_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_cap       <= w_cap_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_sel_nxt   = r_cur_sel;
        w_sel_err_nxt   = r_sel_err;
        w_status_sr_nxt = r_status_sr;
        w_new_sel_nxt   = r_new_sel;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_cap_nxt       = 1'b0;

        if (bus.tap_TestLogicReset) begin
            w_state_nxt     = IDLE;
            w_cur_sel_nxt   = '0;
            w_sel_err_nxt   = 1'b0;
            w_status_sr_nxt = '0;
            w_new_sel_nxt   = '0;
            w_bit_cnt_nxt   = '0;
        end else if (r_state != IDLE && !bus.dbg_sel) begin
            w_state_nxt = IDLE;
        end else if (r_state != IDLE && bus.tap_UpdateDR) begin
            // Commit point: only a fully received index may change the route.
            w_state_nxt = IDLE;
            case (r_state)
                DISCARD: begin
                    if ({1'b0, r_new_sel} < c_ntargets) begin
                        w_cur_sel_nxt = r_new_sel;
                        w_sel_err_nxt = 1'b0;
                    end else begin
                        w_sel_err_nxt = 1'b1;
                    end
                end
                HDR_SEL: w_sel_err_nxt = 1'b1;
                default: ;
            endcase
        end else if (!bus.tap_PauseDR) begin
            case (r_state)
                IDLE: begin
                    if (bus.tap_CaptureDR && bus.dbg_sel && !bus.tap_UpdateDR) begin
                        w_status_sr_nxt = {r_cur_sel, r_sel_err};
                        w_state_nxt     = HDR_FLAG;
                    end
                end
                HDR_FLAG: begin
                    if (bus.tap_ShiftDR) begin
                        w_status_sr_nxt = w_status_shift;
                        if (bus.dbg_tdi == HDR_SELECT) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = HDR_SEL;
                        end else begin
                            w_cap_nxt   = 1'b1;
                            w_state_nxt = ROUTE;
                        end
                    end
                end
                HDR_SEL: begin
                    if (bus.tap_ShiftDR) begin
                        w_new_sel_nxt   = (r_new_sel >> 1) | (SEL_W'(bus.dbg_tdi) << (SEL_W - 1));
                        w_bit_cnt_nxt   = r_bit_cnt + c_cnt_w'(1);
                        w_status_sr_nxt = w_status_shift;
                        if (r_bit_cnt == c_cnt_w'(SEL_W - 1)) begin
                            w_state_nxt = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.tap_ShiftDR) begin
                        w_status_sr_nxt = w_status_shift;
                    end
                end
                ROUTE:   ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_capture = '0;
        w_shift   = '0;
        w_update  = '0;
        if (r_cap) begin
            w_capture[r_cur_sel] = 1'b1;
        end
        if (w_route) begin
            w_shift[r_cur_sel]  = bus.tap_ShiftDR;
            w_update[r_cur_sel] = bus.tap_UpdateDR;
        end
    end

    assign bus.tgt_capture = w_capture;
    assign bus.tgt_shift   = w_shift;
    assign bus.tgt_update  = w_update;
    assign bus.tgt_tdi     = bus.dbg_tdi;
    assign bus.dbg_tdo     = w_route ? bus.tgt_tdo[r_cur_sel] : r_status_sr[0];
    assign bus.cur_sel     = r_cur_sel;
    assign bus.sel_err     = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_dbg_chain_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dbg_chain_arbiter : directed + random scans against a scan model   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_dbg_chain_arbiter;
    import dbg_arb_pkg::*;

    localparam int N  = 3;
    localparam int SW = sel_width(N);

    logic tck;
    logic trstn;

    int n_vec = 0;
    int n_err = 0;

    // Scan-level reference: what the last Capture-DR loaded and which header
    // bits have been seen in the current scan.
    int  m_cur, m_err, m_status, m_sh;
    bit  m_scan, m_cap;
    bit  m_hdr[$];
    bit  chk_en;
    int  route0_shifts;

    dbg_chain_arbiter_if #(.NTARGETS(N)) bus ();

    dbg_chain_arbiter #(.NTARGETS(N)) dut (
        .tap_tck    (tck),
        .jtag_trstn (trstn),
        .bus        (bus)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit routing();
        return m_scan && (m_hdr.size() > 0) && (m_hdr[0] == 1'b0);
    endfunction

    task automatic check_outputs();
        logic [N-1:0] e_sh, e_up, e_cap;
        logic         e_tdo;
        e_sh  = '0;
        e_up  = '0;
        e_cap = '0;
        if (routing()) begin
            e_sh[m_cur] = bus.tap_ShiftDR;
            e_up[m_cur] = bus.tap_UpdateDR;
            e_tdo       = bus.tgt_tdo[m_cur];
        end else begin
            e_tdo = ((m_status >> m_sh) & 1) != 0;
        end
        if (m_cap) e_cap[m_cur] = 1'b1;
        chk("tgt_shift",   32'(bus.tgt_shift),   32'(e_sh));
        chk("tgt_update",  32'(bus.tgt_update),  32'(e_up));
        chk("tgt_capture", 32'(bus.tgt_capture), 32'(e_cap));
        chk("dbg_tdo",     32'(bus.dbg_tdo),     32'(e_tdo));
        chk("tgt_tdi",     32'(bus.tgt_tdi),     32'(bus.dbg_tdi));
        chk("cur_sel",     32'(bus.cur_sel),     32'(m_cur));
        chk("sel_err",     32'(bus.sel_err),     32'(m_err));
        if (bus.tgt_shift[0]) route0_shifts++;
    endtask

    task automatic model_edge();
        int idx;
        m_cap = 1'b0;
        if (!trstn || bus.tap_TestLogicReset) begin
            m_cur = 0; m_err = 0; m_scan = 1'b0; m_status = 0; m_sh = 0;
            m_hdr.delete();
        end else if (m_scan && !bus.dbg_sel) begin
            m_scan = 1'b0;
        end else if (m_scan && bus.tap_UpdateDR) begin
            if (m_hdr.size() > 0 && m_hdr[0] == 1'b1) begin
                if (m_hdr.size() < SW + 1) begin
                    m_err = 1;
                end else begin
                    idx = 0;
                    for (int i = 0; i < SW; i++) idx += int'(m_hdr[1+i]) << i;
                    if (idx < N) begin m_cur = idx; m_err = 0; end
                    else m_err = 1;
                end
            end
            m_scan = 1'b0;
        end else if (bus.tap_PauseDR) begin
            m_scan = m_scan;
        end else if (!m_scan) begin
            if (bus.tap_CaptureDR && bus.dbg_sel && !bus.tap_UpdateDR) begin
                m_scan = 1'b1; m_status = m_cur * 2 + m_err; m_sh = 0;
                m_hdr.delete();
            end
        end else if (bus.tap_ShiftDR && !routing()) begin
            if (m_hdr.size() == 0 && bus.dbg_tdi == 1'b0) m_cap = 1'b1;
            m_hdr.push_back(bus.dbg_tdi);
            m_sh++;
        end
    endtask

    task automatic step(input bit cap, input bit sh, input bit pau, input bit upd, input bit tdi);
        bus.tap_CaptureDR = cap;
        bus.tap_ShiftDR   = sh;
        bus.tap_PauseDR   = pau;
        bus.tap_UpdateDR  = upd;
        bus.dbg_tdi       = tdi;
        bus.tgt_tdo       = N'($urandom);
        #1;
        if (chk_en) check_outputs();
        @(posedge tck);
        model_edge();
        @(negedge tck);
    endtask

    task automatic idle();            step(0, 0, 0, 0, 0);   endtask
    task automatic capture();         step(1, 0, 0, 0, 0);   endtask
    task automatic shift(input bit b); step(0, 1, 0, 0, b);  endtask
    task automatic pause();           step(0, 0, 1, 0, 0);   endtask
    task automatic update();          step(0, 0, 0, 1, 0);   endtask

    task automatic scan_select(input int idx);
        capture();
        shift(1'b1);
        for (int i = 0; i < SW; i++) shift(idx[i]);
        idle();
        update();
        idle();
    endtask

    initial begin
        logic [7:0] data;
        int r, nb;

        trstn  = 1'b0;
        chk_en = 1'b0;
        bus.tap_TestLogicReset = 1'b0;
        bus.tap_CaptureDR = 1'b0;
        bus.tap_ShiftDR   = 1'b0;
        bus.tap_PauseDR   = 1'b0;
        bus.tap_UpdateDR  = 1'b0;
        bus.dbg_sel       = 1'b0;
        bus.dbg_tdi       = 1'b0;
        bus.tgt_tdo       = '0;
        m_cur = 0; m_err = 0; m_status = 0; m_sh = 0; m_scan = 1'b0; m_cap = 1'b0;
        route0_shifts = 0;

        @(negedge tck);
        idle();
        chk_en = 1'b1;
        idle();
        chk("rst_cur_sel", 32'(bus.cur_sel), 0);
        chk("rst_sel_err", 32'(bus.sel_err), 0);
        chk("rst_dbg_tdo", 32'(bus.dbg_tdo), 0);
        trstn = 1'b1;
        bus.dbg_sel = 1'b1;
        idle();

        // Default route to target 0 carrying 0xA5.
        data = 8'hA5;
        capture();
        shift(1'b0);
        chk("cap_pulse_t0", 32'(bus.tgt_capture), 32'h1);
        route0_shifts = 0;
        for (int i = 0; i < 8; i++) shift(data[i]);
        chk("cap_pulse_gone", 32'(bus.tgt_capture), 0);
        idle();
        update();
        chk("route0_shift_cycles", 32'(route0_shifts), 8);
        idle();

        // Valid select of target 2, then a routed scan to it.
        scan_select(2);
        chk("valid_cur_sel", 32'(bus.cur_sel), 2);
        chk("valid_sel_err", 32'(bus.sel_err), 0);
        capture();
        shift(1'b0);
        chk("cap_pulse_t2", 32'(bus.tgt_capture), 32'h4);
        for (int i = 0; i < 4; i++) shift(1'($urandom));
        idle();
        update();
        idle();

        // Out-of-range index 3.
        scan_select(3);
        chk("inval_cur_sel", 32'(bus.cur_sel), 2);
        chk("inval_sel_err", 32'(bus.sel_err), 1);

        // Status readback, then a truncated select with pauses.
        capture();
        chk("status_err_bit", 32'(bus.dbg_tdo), 1);
        shift(1'b1);
        chk("status_cur_lsb", 32'(bus.dbg_tdo), 0);
        shift(1'b0);
        pause();
        pause();
        idle();
        update();
        chk("trunc_cur_sel", 32'(bus.cur_sel), 2);
        chk("trunc_sel_err", 32'(bus.sel_err), 1);
        idle();

        // Pause between index bits must not lose the bit count.
        capture();
        shift(1'b1);
        shift(1'b0);
        pause();
        pause();
        shift(1'b0);
        idle();
        update();
        chk("pause_cur_sel", 32'(bus.cur_sel), 0);
        chk("pause_sel_err", 32'(bus.sel_err), 0);
        idle();

        // Abort by Test-Logic-Reset in the middle of a routed scan.
        scan_select(1);
        chk("sel1_cur_sel", 32'(bus.cur_sel), 1);
        capture();
        shift(1'b0);
        for (int i = 0; i < 3; i++) shift(1'($urandom));
        bus.tap_TestLogicReset = 1'b1;
        idle();
        bus.tap_TestLogicReset = 1'b0;
        update();
        chk("tlr_cur_sel", 32'(bus.cur_sel), 0);
        chk("tlr_sel_err", 32'(bus.sel_err), 0);
        idle();

        // Abort by dropping the debug instruction.
        scan_select(1);
        capture();
        shift(1'b0);
        shift(1'b1);
        shift(1'b0);
        bus.dbg_sel = 1'b0;
        idle();
        update();
        bus.dbg_sel = 1'b1;
        chk("dsel_cur_sel", 32'(bus.cur_sel), 1);
        idle();

        // Synchronous reset while in DISCARD; the following Update commits nothing.
        capture();
        shift(1'b1);
        shift(1'b0);
        shift(1'b1);
        shift(1'b1);
        trstn = 1'b0;
        idle();
        chk("srst_cur_sel", 32'(bus.cur_sel), 0);
        chk("srst_outs", 32'({bus.tgt_capture, bus.tgt_shift, bus.tgt_update, bus.dbg_tdo}), 0);
        trstn = 1'b1;
        update();
        chk("srst_no_commit", 32'(bus.cur_sel), 0);
        idle();

        // Random scans.
        for (int s = 0; s < 80; s++) begin
            capture();
            nb = $urandom_range(0, 6);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 4) == 0) pause();
                shift(1'($urandom));
            end
            r = $urandom_range(0, 11);
            if (r == 0) begin
                bus.dbg_sel = 1'b0;
                idle();
                bus.dbg_sel = 1'b1;
            end else if (r == 1) begin
                bus.tap_TestLogicReset = 1'b1;
                idle();
                bus.tap_TestLogicReset = 1'b0;
            end
            idle();
            update();
            idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
